instr_mem_loader: RTL and testbench

- Program loader: the write side of the byte-addressed, big-endian instruction memory that the fetch path reads asynchronously.
- Accepts a byte stream through a valid/ready handshake and assembles bytes into 32-bit words.
- Issues one word write per 4 bytes into the memory's write port, holding the CPU stalled (cpu_hold) while loading.
- Sits between the host/debug byte source and the instruction memory write port.

---
 rtl/instr_mem_loader_pkg.sv | 33 +++
 rtl/instr_mem_loader_if.sv | 20 ++
 rtl/instr_mem_loader_packer.sv | 31 +++
 rtl/instr_mem_loader.sv | 115 +++++++++++
 tb/tb_instr_mem_loader.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction memory loader: FSM encoding, word size,
// lane insertion helper and a few opcodes used to build test images.
package instr_mem_loader_pkg;

  localparam int INSTR_BYTES = 4;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] J    = 6'b000010;

  // Lane 0 starts a fresh word, so the unwritten lanes of a short tail word
  // are already zero when it is emitted.
  function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w = {b, 24'h000000};
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction memory write port of the loader.
interface instr_mem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output byte_valid, byte_data, byte_last,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data, byte_last,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_mem_loader_packer.sv
// Big-endian word assembly: lane decode and assembly register. word_o already
// contains the byte being accepted this cycle.
module instr_word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);
  logic [31:0] asm_q, asm_d;

  always_comb begin
    word_o = insert_lane(asm_q, lane_i, byte_i);
    asm_d  = asm_q;
    if (clear_i)
      asm_d = '0;
    else if (accept_i)
      asm_d = word_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      asm_q <= '0;
    else
      asm_q <= asm_d;
  end
endmodule

// File: rtl/instr_mem_loader.sv
// Program loader: packs a byte stream into big-endian words and writes them
// into instruction memory while holding the CPU stalled.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int CNT_W       = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  instr_mem_loader_if.slave bus,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_overflow_o,
  output logic [CNT_W-1:0]  byte_count_o
);
  // state | meaning
  // IDLE  | after reset, nothing loaded
  // LOAD  | accepting bytes, CPU held
  // FLUSH | final (possibly padded) word is on the write port
  // DONE  | image complete, CPU released
  // ERR   | image overran memory, CPU kept held

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic        at_limit;
  logic        accept;
  logic        start_ok;
  logic        word_done;
  logic [1:0]  lane;
  logic [31:0] word;

  assign at_limit       = (count_q == CNT_W'(DEPTH_BYTES));
  assign bus.byte_ready = (state_q == LOAD) && !at_limit;
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign lane           = count_q[1:0];
  assign start_ok       = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign word_done      = accept && ((lane == 2'd3) || bus.byte_last);

  instr_word_packer u_packer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (start_ok),
    .accept_i (accept),
    .lane_i   (lane),
    .byte_i   (bus.byte_data),
    .word_o   (word)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          count_d = count_q + CNT_W'(1);
          if (bus.byte_last)
            state_d = FLUSH;
        end else if (bus.byte_valid && at_limit) begin
          state_d = ERR;
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Completed word moves to its own register so assembly continues bubble-free.
    if (word_done) begin
      wr_en_d   = 1'b1;
      wr_addr_d = 32'({count_q[CNT_W-1:2], 2'b00});
      wr_data_d = word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cpu_hold_o     = (state_q == LOAD) || (state_q == FLUSH) || (state_q == ERR);
  assign busy_o         = (state_q == LOAD) || (state_q == FLUSH);
  assign done_o         = (state_q == DONE);
  assign err_overflow_o = (state_q == ERR);
  assign byte_count_o   = count_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a 256-byte and an 8-byte loader share one byte
// stream and are both checked every cycle against a byte-image model.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int CNT_W  = 9;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_FIN  = 2;
  localparam int M_DONE = 3;
  localparam int M_ERR  = 4;

  logic       clk = 1'b0;
  logic       rst, start, valid, last;
  logic [7:0] data;

  logic [1:0]       o_rdy, o_wr_en, o_hold, o_busy, o_done, o_err;
  logic [31:0]      o_addr [2];
  logic [31:0]      o_data [2];
  logic [CNT_W-1:0] o_cnt  [2];

  int n_tests = 0;
  int n_fail  = 0;

  int          depth [2];
  int          ph    [2];
  int          mcnt  [2];
  logic [7:0]  img   [2][256];
  bit          exp_wr   [2];
  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];

  logic [31:0] la0[$], ld0[$], la1[$], ld1[$];

  always #5 clk = ~clk;

  instr_mem_loader_if bus_big ();
  instr_mem_loader_if bus_small ();

  assign bus_big.byte_valid   = valid;
  assign bus_big.byte_data    = data;
  assign bus_big.byte_last    = last;
  assign bus_small.byte_valid = valid;
  assign bus_small.byte_data  = data;
  assign bus_small.byte_last  = last;
  assign o_rdy[0]   = bus_big.byte_ready;
  assign o_wr_en[0] = bus_big.wr_en;
  assign o_addr[0]  = bus_big.wr_addr;
  assign o_data[0]  = bus_big.wr_data;
  assign o_rdy[1]   = bus_small.byte_ready;
  assign o_wr_en[1] = bus_small.wr_en;
  assign o_addr[1]  = bus_small.wr_addr;
  assign o_data[1]  = bus_small.wr_data;

  instr_mem_loader #(.DEPTH_BYTES(256), .CNT_W(CNT_W)) u_big (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus_big),
    .cpu_hold_o(o_hold[0]), .busy_o(o_busy[0]), .done_o(o_done[0]),
    .err_overflow_o(o_err[0]), .byte_count_o(o_cnt[0])
  );

  instr_mem_loader #(.DEPTH_BYTES(8), .CNT_W(CNT_W)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus_small),
    .cpu_hold_o(o_hold[1]), .busy_o(o_busy[1]), .done_o(o_done[1]),
    .err_overflow_o(o_err[1]), .byte_count_o(o_cnt[1])
  );

  function automatic string tag(input string s, input int d);
    return $sformatf("%s[%0d]", s, d);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  function automatic void model_reset(input int d);
    ph[d] = M_IDLE; mcnt[d] = 0; exp_wr[d] = 0; exp_addr[d] = '0; exp_data[d] = '0;
  endfunction

  // One clock of the loader described as a byte image being filled.
  function automatic void model_step(input int d);
    exp_wr[d] = 0;
    if (rst) begin
      model_reset(d);
      return;
    end
    case (ph[d])
      M_IDLE, M_DONE, M_ERR: if (start) begin ph[d] = M_LOAD; mcnt[d] = 0; end
      M_LOAD: if (valid) begin
        if (mcnt[d] < depth[d]) begin
          int a;
          img[d][mcnt[d]] = data;
          mcnt[d]++;
          if (last || (mcnt[d] % 4 == 0)) begin
            a = ((mcnt[d] - 1) / 4) * 4;
            exp_wr[d]   = 1;
            exp_addr[d] = 32'(a);
            exp_data[d] = '0;
            for (int k = 0; k < 4; k++)
              if (a + k < mcnt[d]) exp_data[d] |= 32'(img[d][a+k]) << (8 * (3 - k));
            if (last) ph[d] = M_FIN;
          end
        end else begin
          ph[d] = M_ERR;
        end
      end
      M_FIN:   ph[d] = M_DONE;
      default: ;
    endcase
  endfunction

  task automatic cycle();
    for (int d = 0; d < 2; d++)
      chk(tag("byte_ready", d), o_rdy[d], (ph[d] == M_LOAD) && (mcnt[d] < depth[d]));
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(tag("wr_en", d),    o_wr_en[d], exp_wr[d]);
      chk(tag("wr_addr", d),  o_addr[d],  exp_addr[d]);
      chk(tag("wr_data", d),  o_data[d],  exp_data[d]);
      chk(tag("busy", d),     o_busy[d],  (ph[d] == M_LOAD) || (ph[d] == M_FIN));
      chk(tag("cpu_hold", d), o_hold[d],  (ph[d] == M_LOAD) || (ph[d] == M_FIN) || (ph[d] == M_ERR));
      chk(tag("done", d),     o_done[d],  ph[d] == M_DONE);
      chk(tag("err", d),      o_err[d],   ph[d] == M_ERR);
      chk(tag("count", d),    o_cnt[d],   mcnt[d]);
    end
    if (o_wr_en[0] === 1'b1) begin la0.push_back(o_addr[0]); ld0.push_back(o_data[0]); end
    if (o_wr_en[1] === 1'b1) begin la1.push_back(o_addr[1]); ld1.push_back(o_data[1]); end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid = 0; last = 0; start = 0;
    repeat (n) cycle();
  endtask

  task automatic put(input logic [7:0] b, input bit l, input int gmax);
    int g;
    g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    valid = 0;
    repeat (g) begin
      data = 8'($urandom);
      last = 1'($urandom);
      cycle();
    end
    valid = 1; data = b; last = l;
    cycle();
    valid = 0; last = 0;
  endtask

  task automatic do_start();
    start = 1;
    cycle();
    start = 0;
  endtask

  task automatic clear_logs();
    la0.delete(); ld0.delete(); la1.delete(); ld1.delete();
  endtask

  initial begin
    logic [7:0]  al [8];
    logic [7:0]  bp [12];
    logic [7:0]  ov [9];
    logic [31:0] w0, w1;
    int          len;

    depth[0] = 256;
    depth[1] = 8;
    rst = 1; start = 0; valid = 0; last = 0; data = '0;
    repeat (2) @(negedge clk);
    model_reset(0);
    model_reset(1);
    cycle();
    chk("reset_count", o_cnt[0], 0);
    chk("reset_hold", o_hold[0], 0);
    rst = 0;
    idle(2);

    // Aligned two-word image.
    clear_logs();
    al = '{8'h20, 8'h01, 8'h00, 8'h14, 8'h34, 8'h22, 8'h00, 8'h01};
    w0 = {ADDI, 5'd0, 5'd1, 16'h0014};
    w1 = {ORI, 5'd1, 5'd2, 16'h0001};
    do_start();
    for (int i = 0; i < 8; i++) put(al[i], i == 7, 0);
    idle(3);
    chk("aligned_nwr", la0.size(), 2);
    chk("aligned_a0", la0[0], 32'h0);
    chk("aligned_d0", ld0[0], w0);
    chk("aligned_a1", la0[1], 32'h4);
    chk("aligned_d1", ld0[1], w1);
    chk("aligned_done", o_done[0], 1);
    chk("aligned_small_done", o_done[1], 1);

    // Partial tail word.
    clear_logs();
    do_start();
    put(8'h08, 0, 0); put(8'h00, 0, 0); put(8'h00, 0, 0); put(8'h00, 0, 0); put(8'hAB, 1, 0);
    idle(3);
    chk("partial_nwr", la0.size(), 2);
    chk("partial_d0", ld0[0], {J, 26'h0});
    chk("partial_a1", la0[1], 32'h4);
    chk("partial_d1", ld0[1], 32'hAB000000);
    chk("partial_count", o_cnt[0], 5);
    chk("partial_done", o_done[0], 1);

    // Gapped stream of 12 bytes.
    clear_logs();
    for (int i = 0; i < 12; i++) bp[i] = 8'($urandom);
    do_start();
    for (int i = 0; i < 12; i++) put(bp[i], i == 11, 3);
    idle(3);
    chk("gap_nwr", la0.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("gap_a%0d", k), la0[k], 32'(4 * k));
      chk($sformatf("gap_d%0d", k), ld0[k], {bp[4*k], bp[4*k+1], bp[4*k+2], bp[4*k+3]});
    end
    chk("gap_small_err", o_err[1], 1);

    // start pulsed mid-load is ignored.
    clear_logs();
    do_start();
    put(8'h11, 0, 1); put(8'h22, 0, 1);
    start = 1;
    put(8'h33, 0, 0);
    start = 0;
    put(8'h44, 1, 0);
    idle(3);
    chk("ign_count", o_cnt[0], 4);
    chk("ign_nwr", la0.size(), 1);
    chk("ign_d0", ld0[0], 32'h11223344);

    // Reset in the middle of a load.
    clear_logs();
    do_start();
    put(8'hC1, 0, 0); put(8'hC2, 0, 0); put(8'hC3, 0, 0);
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_nwr", la0.size(), 0);
    chk("rst_count", o_cnt[0], 0);
    chk("rst_hold", o_hold[0], 0);
    do_start();
    put(8'hDE, 0, 0); put(8'hAD, 0, 0); put(8'hBE, 0, 0); put(8'hEF, 1, 0);
    idle(3);
    chk("rst_reload_nwr", la0.size(), 1);
    chk("rst_reload_a0", la0[0], 32'h0);
    chk("rst_reload_d0", ld0[0], 32'hDEADBEEF);

    // Overflow of the 8-byte loader.
    clear_logs();
    for (int i = 0; i < 9; i++) ov[i] = 8'($urandom);
    do_start();
    for (int i = 0; i < 8; i++) put(ov[i], 0, 2);
    idle(1);
    chk("ovf_small_ready", o_rdy[1], 0);
    chk("ovf_big_ready", o_rdy[0], 1);
    put(ov[8], 0, 0);
    idle(2);
    chk("ovf_nwr", la1.size(), 2);
    chk("ovf_a1", la1[1], 32'h4);
    chk("ovf_d1", ld1[1], {ov[4], ov[5], ov[6], ov[7]});
    chk("ovf_err", o_err[1], 1);
    chk("ovf_hold", o_hold[1], 1);
    chk("ovf_done", o_done[1], 0);
    put(8'h5A, 1, 0);
    idle(3);
    chk("ovf_big_nwr", la0.size(), 3);
    chk("ovf_big_d2", ld0[2], {ov[8], 8'h5A, 16'h0000});
    chk("ovf_small_nwr", la1.size(), 2);
    do_start();
    for (int i = 0; i < 4; i++) put(8'(i + 1), i == 3, 1);
    idle(3);
    chk("ovf_recover_done", o_done[1], 1);
    chk("ovf_recover_d", ld1[2], 32'h01020304);

    // Random images of assorted lengths.
    repeat (6) begin
      len = int'($urandom_range(12, 1));
      do_start();
      for (int i = 0; i < len; i++) put(8'($urandom), i == len - 1, 2);
      idle(3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
